// File: rtl/sram_bus_arbiter_if.sv
// Signal bundle for sram_bus_arbiter: the fetch (inst) and execute (data)
// sram-like request ports plus the shared downstream bus.
// slave  : arbiter view (takes requests, drives the shared bus).
// master : environment view (pipeline stages and bus bridge).
interface sram_bus_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: merges the inst and data sram-like ports onto one shared
// bus. Accepted transactions are tracked in an in-order FIFO of source ids so
// each bus_data_ok is routed back to the side that issued it.
// Optional feature: define ARB_RR_EN for round-robin arbitration between the
// two sides; otherwise fixed priority data > inst.
module sram_bus_arbiter #(
  parameter int unsigned OT_DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  sram_bus_arbiter_if.slave io
);

  localparam int unsigned PW = $clog2(OT_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OT_DEPTH);

  typedef enum logic {ST_IDLE, ST_LOCK} state_e;
  typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} src_e;

  state_e        state_q, state_d;
  src_e          grant_q, grant_d;
  src_e          fifo_q [OT_DEPTH];
  src_e          fifo_d [OT_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
`ifdef ARB_RR_EN
  src_e          rr_q, rr_d;
`endif

  src_e sel;
  logic any_req;
  logic full;
  logic push;
  logic pop;
  src_e head;

  // Request path: pick the granted source and drive the shared bus fields.
  always_comb begin
    sel     = SRC_DATA;
    any_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        any_req = io.inst_req | io.data_req;
        if (io.inst_req && io.data_req) begin
`ifdef ARB_RR_EN
          sel = rr_q;
`else
          sel = SRC_DATA;
`endif
        end else if (io.inst_req) begin
          sel = SRC_INST;
        end
      end
      ST_LOCK: begin
        any_req = 1'b1;
        sel     = grant_q;
      end
      default: ;
    endcase

    full       = (count_q == FULL_CNT);
    io.bus_req = any_req && !full && !reset;
    push       = io.bus_req && io.bus_addr_ok;

    io.bus_wr    = 1'b0;
    io.bus_size  = 2'd0;
    io.bus_wstrb = '0;
    io.bus_addr  = '0;
    io.bus_wdata = '0;
    if (any_req && !reset) begin
      if (sel == SRC_DATA) begin
        io.bus_wr    = io.data_wr;
        io.bus_size  = io.data_size;
        io.bus_wstrb = io.data_wstrb;
        io.bus_addr  = io.data_addr;
        io.bus_wdata = io.data_wdata;
      end else begin
        io.bus_size  = 2'd2;
        io.bus_addr  = io.inst_addr;
      end
    end

    io.inst_addr_ok = push && (sel == SRC_INST);
    io.data_addr_ok = push && (sel == SRC_DATA);
  end

  // Response path: a bus_data_ok retires the FIFO head; ignored when empty.
  always_comb begin
    head            = fifo_q[rd_ptr_q];
    pop             = io.bus_data_ok && (count_q != '0);
    io.inst_data_ok = pop && (head == SRC_INST);
    io.data_data_ok = pop && (head == SRC_DATA);
    io.inst_rdata   = io.bus_rdata;
    io.data_rdata   = io.bus_rdata;
  end

  // Next state: lock on a stalled request, track outstanding ids in order.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
`ifdef ARB_RR_EN
    rr_d     = rr_q;
    if (push) rr_d = src_e'(~rr_q);
`endif

    case (state_q)
      ST_IDLE: begin
        if (io.bus_req && !io.bus_addr_ok) begin
          state_d = ST_LOCK;
          grant_d = sel;
        end
      end
      ST_LOCK: begin
        if (push) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= SRC_DATA;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < OT_DEPTH; i++) fifo_q[i] <= SRC_INST;
`ifdef ARB_RR_EN
      rr_q     <= SRC_DATA;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fifo_q   <= fifo_d;
`ifdef ARB_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: arbitration, lock, FIFO routing,
// full back-pressure, async reset and (optionally) round-robin grants.
module tb_sram_bus_arbiter;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  sram_bus_arbiter_if bus_if ();

  sram_bus_arbiter #(.OT_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus_if.inst_req    = 1'b0;
    bus_if.inst_addr   = '0;
    bus_if.data_req    = 1'b0;
    bus_if.data_wr     = 1'b0;
    bus_if.data_size   = 2'd0;
    bus_if.data_wstrb  = '0;
    bus_if.data_addr   = '0;
    bus_if.data_wdata  = '0;
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b0;
    bus_if.bus_rdata   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic exp_d;
    clk          = 1'b0;
    reset        = 1'b1;
    tests_run    = 0;
    tests_failed = 0;
    clear_inputs();

    // Reset state: requests present but reset holds every output low.
    bus_if.inst_req  = 1'b1;
    bus_if.data_req  = 1'b1;
    bus_if.data_addr = 32'h1C00_0000;
    bus_if.bus_addr_ok = 1'b1;
    settle();
    check("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_bus_addr", bus_if.bus_addr, 32'h0);
    check("rst_data_addr_ok", 32'(bus_if.data_addr_ok), 32'd0);
    check("rst_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'd0);
    next_cycle();

    // 1: both request, data first, responses routed in order.
    do_reset();
    bus_if.inst_req    = 1'b1;
    bus_if.inst_addr   = 32'hBFC0_0000;
    bus_if.data_req    = 1'b1;
    bus_if.data_size   = 2'd2;
    bus_if.data_addr   = 32'h1C00_0040;
    bus_if.bus_addr_ok = 1'b1;
    settle();
    check("t1_c0_data_addr_ok", 32'(bus_if.data_addr_ok), 32'd1);
    check("t1_c0_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'd0);
    check("t1_c0_bus_addr", bus_if.bus_addr, 32'h1C00_0040);
    next_cycle();
    bus_if.data_req = 1'b0;
    settle();
    check("t1_c1_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'd1);
    check("t1_c1_bus_size", 32'(bus_if.bus_size), 32'd2);
    check("t1_c1_bus_addr", bus_if.bus_addr, 32'hBFC0_0000);
    next_cycle();
    bus_if.inst_req    = 1'b0;
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata   = 32'hDEAD_0001;
    settle();
    check("t1_c2_data_data_ok", 32'(bus_if.data_data_ok), 32'd1);
    check("t1_c2_inst_data_ok", 32'(bus_if.inst_data_ok), 32'd0);
    check("t1_c2_data_rdata", bus_if.data_rdata, 32'hDEAD_0001);
    next_cycle();
    bus_if.bus_rdata = 32'h1234_5678;
    settle();
    check("t1_c3_inst_data_ok", 32'(bus_if.inst_data_ok), 32'd1);
    check("t1_c3_data_data_ok", 32'(bus_if.data_data_ok), 32'd0);
    check("t1_c3_inst_rdata", bus_if.inst_rdata, 32'h1234_5678);
    next_cycle();

    // 2: stalled data write locks the bus until bus_addr_ok.
    do_reset();
    bus_if.data_req    = 1'b1;
    bus_if.data_wr     = 1'b1;
    bus_if.data_size   = 2'd2;
    bus_if.data_wstrb  = 4'hF;
    bus_if.data_addr   = 32'h1C00_0100;
    bus_if.data_wdata  = 32'hCAFE_F00D;
    settle();
    check("t2_c0_bus_req", 32'(bus_if.bus_req), 32'd1);
    check("t2_c0_bus_addr", bus_if.bus_addr, 32'h1C00_0100);
    next_cycle();
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'hBFC0_0010;
    for (int i = 1; i < 3; i++) begin
      settle();
      check($sformatf("t2_c%0d_bus_addr", i), bus_if.bus_addr, 32'h1C00_0100);
      check($sformatf("t2_c%0d_bus_wr", i), 32'(bus_if.bus_wr), 32'd1);
      check($sformatf("t2_c%0d_inst_addr_ok", i), 32'(bus_if.inst_addr_ok), 32'd0);
      next_cycle();
    end
    bus_if.bus_addr_ok = 1'b1;
    settle();
    check("t2_c3_data_addr_ok", 32'(bus_if.data_addr_ok), 32'd1);
    check("t2_c3_bus_wdata", bus_if.bus_wdata, 32'hCAFE_F00D);
    check("t2_c3_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'd0);
    next_cycle();
    bus_if.data_req = 1'b0;
    settle();
    check("t2_c4_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'd1);
    check("t2_c4_bus_addr", bus_if.bus_addr, 32'hBFC0_0010);
    check("t2_c4_bus_wdata", bus_if.bus_wdata, 32'h0);
    check("t2_c4_bus_wstrb", 32'(bus_if.bus_wstrb), 32'd0);
    next_cycle();

    // 3: FIFO full blocks requests; accepted the cycle after a pop.
    do_reset();
    bus_if.inst_req    = 1'b1;
    bus_if.inst_addr   = 32'hBFC0_0020;
    bus_if.bus_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("t3_hs%0d_inst_addr_ok", i), 32'(bus_if.inst_addr_ok), 32'd1);
      next_cycle();
    end
    settle();
    check("t3_full_bus_req", 32'(bus_if.bus_req), 32'd0);
    check("t3_full_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'd0);
    next_cycle();
    bus_if.bus_data_ok = 1'b1;
    settle();
    check("t3_pop_inst_data_ok", 32'(bus_if.inst_data_ok), 32'd1);
    check("t3_pop_bus_req", 32'(bus_if.bus_req), 32'd0);
    check("t3_pop_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'd0);
    next_cycle();
    bus_if.bus_data_ok = 1'b0;
    settle();
    check("t3_after_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'd1);
    next_cycle();

    // 4: push and pop in the same cycle keep order and count.
    do_reset();
    bus_if.inst_req    = 1'b1;
    bus_if.bus_addr_ok = 1'b1;
    next_cycle();
    bus_if.inst_req = 1'b0;
    bus_if.data_req = 1'b1;
    next_cycle();
    bus_if.bus_data_ok = 1'b1;
    settle();
    check("t4_same_data_addr_ok", 32'(bus_if.data_addr_ok), 32'd1);
    check("t4_same_inst_data_ok", 32'(bus_if.inst_data_ok), 32'd1);
    check("t4_same_data_data_ok", 32'(bus_if.data_data_ok), 32'd0);
    next_cycle();
    bus_if.data_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("t4_ret%0d_data_data_ok", i), 32'(bus_if.data_data_ok), 32'd1);
      check($sformatf("t4_ret%0d_inst_data_ok", i), 32'(bus_if.inst_data_ok), 32'd0);
      next_cycle();
    end
    settle();
    check("t4_empty_data_data_ok", 32'(bus_if.data_data_ok), 32'd0);
    check("t4_empty_inst_data_ok", 32'(bus_if.inst_data_ok), 32'd0);
    next_cycle();

    // 5: async reset in LOCK with three outstanding.
    do_reset();
    bus_if.inst_req    = 1'b1;
    bus_if.bus_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) next_cycle();
    bus_if.inst_req    = 1'b0;
    bus_if.data_req    = 1'b1;
    bus_if.data_addr   = 32'h1C00_0200;
    bus_if.bus_addr_ok = 1'b0;
    next_cycle();
    settle();
    check("t5_lock_bus_req", 32'(bus_if.bus_req), 32'd1);
    check("t5_lock_bus_addr", bus_if.bus_addr, 32'h1C00_0200);
    #1;
    reset = 1'b1;
    #1;
    check("t5_rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    check("t5_rst_bus_addr", bus_if.bus_addr, 32'h0);
    next_cycle();
    reset              = 1'b0;
    bus_if.data_req    = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    settle();
    check("t5_post_inst_data_ok", 32'(bus_if.inst_data_ok), 32'd0);
    check("t5_post_data_data_ok", 32'(bus_if.data_data_ok), 32'd0);
    next_cycle();
    bus_if.bus_data_ok = 1'b0;
    bus_if.inst_req    = 1'b1;
    bus_if.bus_addr_ok = 1'b1;
    settle();
    check("t5_idle_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'd1);
    next_cycle();

    // 6: both sides request every cycle.
    do_reset();
    bus_if.inst_req    = 1'b1;
    bus_if.data_req    = 1'b1;
    bus_if.bus_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      settle();
      check($sformatf("t6_g%0d_data_addr_ok", i), 32'(bus_if.data_addr_ok), 32'(exp_d));
      check($sformatf("t6_g%0d_inst_addr_ok", i), 32'(bus_if.inst_addr_ok), 32'(!exp_d));
      next_cycle();
    end
    clear_inputs();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
